// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC traffic generator.
// Holds the flit-type and FSM-state enums, default field widths, the packed
// flit layout for the default configuration and the LFSR step function.
package noc_pkg;

  localparam int unsigned DEF_FLIT_W  = 64;
  localparam int unsigned DEF_COORD_W = 2;
  localparam int unsigned FTYPE_W     = 2;
  localparam int unsigned PKT_ID_W    = 16;
  localparam int unsigned FLIT_IDX_W  = 8;
  localparam int unsigned DEF_PAYLOAD_W = DEF_FLIT_W - 2 * DEF_COORD_W - FTYPE_W;

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [FTYPE_W-1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_TAIL,
    ST_GAP,
    ST_DONE
  } state_e;

  // Flit layout, MSB first, for the default widths
  typedef struct packed {
    logic [DEF_COORD_W-1:0]   x_dest;
    logic [DEF_COORD_W-1:0]   y_dest;
    flit_type_e               ftype;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } flit_t;

  // One LFSR advance
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/noc_lfsr32.sv
// 32-bit Galois LFSR, loads seed on reset and advances once per adv cycle.
// Ports: clk, rst (async, active-high), adv (advance enable),
//        seed (reset value, must be nonzero), value (current state).
module noc_lfsr32
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (adv) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Wormhole traffic generator driving one router input port.
// Emits packets of head/body/tail (or single) flits carrying a fixed or
// LFSR-random X/Y destination and a self-checking payload, honouring
// buffer_on_in backpressure.
// Ports: clk, rst (async, active-high), start (run pulse), stop (level,
//        ends run after current tail), dest_mode/dest_x/dest_y (destination
//        select), flit_out/valid_out (flit channel), buffer_on_in (downstream
//        ready), busy, done, pkt_count (tails accepted), stall_count.
// Build option: define NOC_TRAFFIC_GEN_STALL_CNT_EN to build the stall
// counter; otherwise stall_count is tied to zero.
module noc_traffic_gen
  import noc_pkg::*;
#(
  parameter int unsigned             FLIT_WIDTH  = DEF_FLIT_W,
  parameter int unsigned             COORD_WIDTH = DEF_COORD_W,
  parameter int unsigned             PKT_LEN     = 4,
  parameter int unsigned             NUM_PKTS    = 16,
  parameter int unsigned             GAP_CYCLES  = 0,
  parameter logic [COORD_WIDTH-1:0]  X_CURRENT   = COORD_WIDTH'(1),
  parameter logic [COORD_WIDTH-1:0]  Y_CURRENT   = COORD_WIDTH'(1),
  parameter logic [31:0]             SEED        = 32'h1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   dest_mode,
  input  logic [COORD_WIDTH-1:0] dest_x,
  input  logic [COORD_WIDTH-1:0] dest_y,
  output logic [FLIT_WIDTH-1:0]  flit_out,
  output logic                   valid_out,
  input  logic                   buffer_on_in,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output logic [31:0]            stall_count
);

  localparam int unsigned PAYLOAD_W    = FLIT_WIDTH - 2 * COORD_WIDTH - FTYPE_W;
  localparam int unsigned LFSR_FIELD_W = PAYLOAD_W - PKT_ID_W - FLIT_IDX_W;
  localparam logic [FLIT_IDX_W-1:0] LAST_IDX   = FLIT_IDX_W'(PKT_LEN - 1);
  localparam logic [7:0]            GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [15:0]           PKT_TARGET = 16'(NUM_PKTS);
  localparam flit_type_e            HEAD_TYPE  = (PKT_LEN == 1) ? FT_SINGLE : FT_HEAD;

  state_e                  state;
  logic [FLIT_IDX_W-1:0]   flit_idx;
  logic [7:0]              gap_cnt;
  logic [COORD_WIDTH-1:0]  dest_x_q;
  logic [COORD_WIDTH-1:0]  dest_y_q;

  logic                    accept;
  logic [31:0]             lfsr_val;
  logic [31:0]             lfsr_fmt;
  logic [COORD_WIDTH-1:0]  head_x;
  logic [COORD_WIDTH-1:0]  head_y;
  logic [15:0]             pkt_count_inc;
  logic [15:0]             head_id;
  logic [FLIT_IDX_W-1:0]   nxt_idx;
  logic                    nxt_is_tail;
  logic                    last_pkt;
  logic                    start_ok;
  logic                    eop;
  logic                    form_head;
  logic [FLIT_WIDTH-1:0]   head_flit;
  logic [FLIT_WIDTH-1:0]   cont_flit;

  // Assemble one flit from its fields
  function automatic logic [FLIT_WIDTH-1:0] make_flit(
    input logic [COORD_WIDTH-1:0] fx,
    input logic [COORD_WIDTH-1:0] fy,
    input flit_type_e             ft,
    input logic [15:0]            id,
    input logic [FLIT_IDX_W-1:0]  idx,
    input logic [31:0]            lv
  );
    logic [PAYLOAD_W-1:0] pl;
    pl = '0;
    pl[PAYLOAD_W-1 -: PKT_ID_W] = id;
    if (ft == FT_HEAD || ft == FT_SINGLE) begin
      pl[PAYLOAD_W-PKT_ID_W-FLIT_IDX_W-1 -: 2*COORD_WIDTH] = {X_CURRENT, Y_CURRENT};
    end else begin
      pl[PAYLOAD_W-PKT_ID_W-1 -: FLIT_IDX_W] = idx;
      pl[LFSR_FIELD_W-1:0] = LFSR_FIELD_W'(lv);
    end
    return {fx, fy, ft, pl};
  endfunction

  noc_lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (accept),
    .seed  (SEED),
    .value (lfsr_val)
  );

  assign accept = valid_out & buffer_on_in;

  // A flit formed on an accept edge sees the post-advance LFSR value, so the
  // value embedded in a flit equals the LFSR state while that flit is shown.
  assign lfsr_fmt = accept ? lfsr_step(lfsr_val) : lfsr_val;

  assign head_x = dest_mode ? dest_x : lfsr_fmt[COORD_WIDTH-1:0];
  assign head_y = dest_mode ? dest_y : lfsr_fmt[2*COORD_WIDTH-1 -: COORD_WIDTH];

  assign pkt_count_inc = pkt_count + 16'd1;
  assign last_pkt      = ((NUM_PKTS != 0) && (pkt_count_inc == PKT_TARGET)) || stop;
  assign nxt_idx       = flit_idx + FLIT_IDX_W'(1);
  assign nxt_is_tail   = (nxt_idx == LAST_IDX);

  assign start_ok  = (state == ST_IDLE || state == ST_DONE) && start;
  assign eop       = accept && (state == ST_TAIL || (state == ST_HEAD && PKT_LEN == 1));
  assign form_head = start_ok
                   || (eop && !last_pkt && GAP_CYCLES == 0)
                   || (state == ST_GAP && gap_cnt == GAP_LAST);

  // Candidate next flits: a new head, or the next body/tail of this packet
  always_comb begin
    head_id = pkt_count_inc;
    if (state == ST_IDLE || state == ST_DONE) begin
      head_id = '0;
    end else if (state == ST_GAP) begin
      head_id = pkt_count;
    end
    head_flit = make_flit(head_x, head_y, HEAD_TYPE, head_id, '0, lfsr_fmt);
    cont_flit = make_flit(dest_x_q, dest_y_q, nxt_is_tail ? FT_TAIL : FT_BODY,
                          pkt_count, nxt_idx, lfsr_fmt);
  end

  // Packet sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flit_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
      flit_idx  <= '0;
      gap_cnt   <= '0;
      dest_x_q  <= '0;
      dest_y_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pkt_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_HEAD, ST_BODY, ST_TAIL: begin
          if (accept) begin
            if (eop) begin
              pkt_count <= pkt_count_inc;
              if (last_pkt) begin
                valid_out <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= ST_DONE;
              end else if (!form_head) begin
                valid_out <= 1'b0;
                gap_cnt   <= '0;
                state     <= ST_GAP;
              end
            end else begin
              flit_out <= cont_flit;
              flit_idx <= nxt_idx;
              state    <= nxt_is_tail ? ST_TAIL : ST_BODY;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Head formation overrides the per-state updates above
      if (form_head) begin
        flit_out  <= head_flit;
        valid_out <= 1'b1;
        flit_idx  <= '0;
        dest_x_q  <= head_x;
        dest_y_q  <= head_y;
        state     <= ST_HEAD;
      end
    end
  end

`ifdef NOC_TRAFFIC_GEN_STALL_CNT_EN
  // Saturating count of cycles a valid flit waits on downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (start_ok) begin
      stall_count <= '0;
    end else if (valid_out && !buffer_on_in && stall_count != '1) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed testbench for noc_traffic_gen using three configurations:
// A: 4-flit packets, 2 per run; B: single-flit packets with a 2-cycle gap;
// C: 4-flit packets, unbounded run, random destinations, stop and reset.
module tb_noc_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        a_start = 1'b0, a_stop = 1'b0, a_mode = 1'b1, a_buf = 1'b1;
  logic [1:0]  a_dx = 2'd2, a_dy = 2'd1;
  logic [63:0] a_flit;
  logic        a_valid, a_busy, a_done;
  logic [15:0] a_cnt;
  logic [31:0] a_stall;

  logic        b_start = 1'b0, b_stop = 1'b0, b_mode = 1'b1, b_buf = 1'b1;
  logic [1:0]  b_dx = 2'd3, b_dy = 2'd0;
  logic [63:0] b_flit;
  logic        b_valid, b_busy, b_done;
  logic [15:0] b_cnt;
  logic [31:0] b_stall;

  logic        c_start = 1'b0, c_stop = 1'b0, c_mode = 1'b0, c_buf = 1'b1;
  logic [1:0]  c_dx = 2'd0, c_dy = 2'd0;
  logic [63:0] c_flit;
  logic        c_valid, c_busy, c_done;
  logic [15:0] c_cnt;
  logic [31:0] c_stall;

  localparam logic [31:0] C_SEED = 32'hACE1_234B;

`ifdef NOC_TRAFFIC_GEN_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd3;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] a_lfsr = 32'h1;
  logic [31:0] c_lfsr = C_SEED;

  noc_traffic_gen #(.PKT_LEN(4), .NUM_PKTS(2), .GAP_CYCLES(0), .SEED(32'h1)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .dest_mode(a_mode),
    .dest_x(a_dx), .dest_y(a_dy), .flit_out(a_flit), .valid_out(a_valid),
    .buffer_on_in(a_buf), .busy(a_busy), .done(a_done), .pkt_count(a_cnt),
    .stall_count(a_stall)
  );

  noc_traffic_gen #(.PKT_LEN(1), .NUM_PKTS(3), .GAP_CYCLES(2), .SEED(32'h1)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .dest_mode(b_mode),
    .dest_x(b_dx), .dest_y(b_dy), .flit_out(b_flit), .valid_out(b_valid),
    .buffer_on_in(b_buf), .busy(b_busy), .done(b_done), .pkt_count(b_cnt),
    .stall_count(b_stall)
  );

  noc_traffic_gen #(.PKT_LEN(4), .NUM_PKTS(0), .GAP_CYCLES(0),
                    .X_CURRENT(2'd3), .Y_CURRENT(2'd0), .SEED(C_SEED)) u_dut_c (
    .clk(clk), .rst(rst), .start(c_start), .stop(c_stop), .dest_mode(c_mode),
    .dest_x(c_dx), .dest_y(c_dy), .flit_out(c_flit), .valid_out(c_valid),
    .buffer_on_in(c_buf), .busy(c_busy), .done(c_done), .pkt_count(c_cnt),
    .stall_count(c_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: shift right, feed the dropped bit into taps 31,21,1,0
  function automatic logic [31:0] m_step(input logic [31:0] v);
    logic        fb;
    logic [31:0] n;
    fb = v[0];
    n  = {1'b0, v[31:1]};
    n[31] = n[31] ^ fb;
    n[21] = n[21] ^ fb;
    n[1]  = n[1] ^ fb;
    n[0]  = n[0] ^ fb;
    return n;
  endfunction

  function automatic logic [1:0] ftype4(input int k);
    if (k == 0) return 2'b00;
    if (k == 3) return 2'b10;
    return 2'b01;
  endfunction

  // Expected flit for 64-bit flits with 2-bit coordinates
  function automatic logic [63:0] mk(input logic [1:0] x, input logic [1:0] y,
                                     input logic [1:0] t, input logic [15:0] id,
                                     input logic [7:0] idx, input logic [31:0] lv,
                                     input logic [1:0] xc, input logic [1:0] yc);
    logic [57:0] pl;
    if (t == 2'b00 || t == 2'b11) pl = {id, 8'h00, xc, yc, 30'h0};
    else pl = {id, idx, 2'b00, lv};
    return {x, y, t, pl};
  endfunction

  // Two 4-flit packets on A with an optional backpressure window
  task automatic run_a(input int stall_at, input int stall_len, input logic [31:0] exp_stall);
    int acc;
    int cyc;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 100) begin
      a_buf = !(cyc >= stall_at && cyc < stall_at + stall_len);
      check("a_valid", 64'(a_valid), 64'd1);
      check("a_busy", 64'(a_busy), 64'd1);
      check("a_flit", a_flit, mk(2'd2, 2'd1, ftype4(acc % 4), 16'(acc / 4), 8'(acc % 4),
                                 a_lfsr, 2'd1, 2'd1));
      if (a_buf) begin
        acc++;
        a_lfsr = m_step(a_lfsr);
      end
      tick();
      cyc++;
    end
    a_buf = 1'b1;
    check("a_flits_accepted", 64'(acc), 64'd8);
    check("a_valid_end", 64'(a_valid), 64'd0);
    check("a_busy_end", 64'(a_busy), 64'd0);
    check("a_done_end", 64'(a_done), 64'd1);
    check("a_pkt_count", 64'(a_cnt), 64'd2);
    check("a_stall_count", 64'(a_stall), 64'(exp_stall));
  endtask

  initial begin
    int acc;
    int cyc;
    logic [1:0] hx;
    logic [1:0] hy;
    logic exp_v;
    hx = 2'd0;
    hy = 2'd0;

    tick();
    tick();
    check("rst_a_flit", a_flit, 64'd0);
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_done", 64'(a_done), 64'd0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_a_stall", 64'(a_stall), 64'd0);
    rst = 1'b0;
    tick();

    // A: clean run, then a run with three stall cycles mid-body
    run_a(-1, 0, 32'd0);
    tick();
    run_a(2, 3, STALL_EXP);

    // B: single-flit packets, each followed by two idle cycles
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_v = (i % 3 == 0);
      check("b_valid", 64'(b_valid), 64'(exp_v));
      if (exp_v) check("b_flit", b_flit, mk(2'd3, 2'd0, 2'b11, 16'(i / 3), 8'd0, 32'd0, 2'd1, 2'd1));
      tick();
    end
    check("b_valid_end", 64'(b_valid), 64'd0);
    check("b_done_end", 64'(b_done), 64'd1);
    check("b_pkt_count", 64'(b_cnt), 64'd3);

    // C: stop while idle does nothing
    c_stop = 1'b1;
    tick();
    tick();
    tick();
    check("c_idle_stop_valid", 64'(c_valid), 64'd0);
    check("c_idle_stop_busy", 64'(c_busy), 64'd0);
    check("c_idle_stop_done", 64'(c_done), 64'd0);
    c_stop = 1'b0;

    // C: 64 random-destination packets; stop raised on the last packet's second body
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 256 && cyc < 400) begin
      if (acc % 4 == 0) begin
        hx = c_lfsr[1:0];
        hy = c_lfsr[3:2];
      end
      if (acc == 254) c_stop = 1'b1;
      check("c_valid", 64'(c_valid), 64'd1);
      check("c_flit", c_flit, mk(hx, hy, ftype4(acc % 4), 16'(acc / 4), 8'(acc % 4),
                                 c_lfsr, 2'd3, 2'd0));
      acc++;
      c_lfsr = m_step(c_lfsr);
      tick();
      cyc++;
    end
    c_stop = 1'b0;
    check("c_flits_accepted", 64'(acc), 64'd256);
    check("c_valid_end", 64'(c_valid), 64'd0);
    check("c_busy_end", 64'(c_busy), 64'd0);
    check("c_done_end", 64'(c_done), 64'd1);
    check("c_pkt_count", 64'(c_cnt), 64'd64);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("c_no_more_heads", 64'(c_valid), 64'd0);
    end

    // C: restart, abandon mid-packet with reset, restart from seed
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("c_mid_pkt_count", 64'(c_cnt), 64'd1);
    check("c_mid_valid", 64'(c_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("c_rst_valid_async", 64'(c_valid), 64'd0);
    check("c_rst_cnt", 64'(c_cnt), 64'd0);
    tick();
    check("c_rst_valid_held", 64'(c_valid), 64'd0);
    rst = 1'b0;
    tick();
    c_lfsr = C_SEED;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("c_post_rst_valid", 64'(c_valid), 64'd1);
    check("c_post_rst_head", c_flit, mk(c_lfsr[1:0], c_lfsr[3:2], 2'b00, 16'd0, 8'd0,
                                        c_lfsr, 2'd3, 2'd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
